// File: rtl/wb_byte_ctrl_pkg.sv
// Shared definitions for wb_byte_ctrl.
// - Wishbone controller/peripheral bundles (iWishbone_Ctrl, iWishbone_Peri)
// - Controller FSM state enum
// - Command byte field positions and response byte codes
package wb_byte_ctrl_pkg;

  localparam int unsigned WB_ADR_W = 8;
  localparam int unsigned WB_DAT_W = 8;

  // Controller -> peripheral
  typedef struct packed {
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } iWishbone_Ctrl;

  // Peripheral -> controller
  typedef struct packed {
    logic                ack;
    logic [WB_DAT_W-1:0] dat;
  } iWishbone_Peri;

  typedef enum logic [1:0] {
    StIdle,
    StGetData,
    StWbCycle,
    StSend
  } state_e;

  localparam int unsigned CMD_WE_BIT  = 7;
  localparam int unsigned CMD_ADR_LSB = 0;
  localparam int unsigned CMD_ADR_W   = 4;

  localparam logic [7:0] RESP_OK      = 8'h00;
  localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

endpackage

// File: rtl/wb_byte_ctrl.sv
// Byte-stream driven Wishbone controller.
// Each command byte (bit7 = we, bits[3:0] = adr) produces one classic Wishbone
// cycle and exactly one response byte (read data, RESP_OK or RESP_TIMEOUT).
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   wb_c         controller bundle (stb, we, adr, dat) - all registered
//   wb_p         peripheral bundle (ack, dat)
//   rx_*         inbound byte stream (valid/ready)
//   tx_*         outbound response stream (valid/ready), held until accepted
//   timeout_err  sticky flag, set when a cycle is aborted for lack of ack
module wb_byte_ctrl
  import wb_byte_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  output iWishbone_Ctrl wb_c,
  input  iWishbone_Peri wb_p,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  iWishbone_Ctrl wb_q, wb_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          terr_q, terr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          rx_ready_int;

  // Reserved command bits are deliberately ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^rx_data[6:4];

  always_comb begin
    state_d      = state_q;
    wb_d         = wb_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    terr_d       = terr_q;
    cnt_d        = cnt_q;
    rx_ready_int = 1'b0;

    unique case (state_q)
      StIdle: begin
        rx_ready_int = 1'b1;
        if (rx_valid) begin
          wb_d.we  = rx_data[CMD_WE_BIT];
          wb_d.adr = WB_ADR_W'(rx_data[CMD_ADR_LSB +: CMD_ADR_W]);
          if (rx_data[CMD_WE_BIT]) begin
            state_d = StGetData;
          end else begin
            wb_d.stb = 1'b1;
            cnt_d    = '0;
            state_d  = StWbCycle;
          end
        end
      end

      StGetData: begin
        rx_ready_int = 1'b1;
        if (rx_valid) begin
          wb_d.dat = rx_data;
          wb_d.stb = 1'b1;
          wb_d.we  = 1'b1;
          cnt_d    = '0;
          state_d  = StWbCycle;
        end
      end

      StWbCycle: begin
        // ack wins over a timeout landing on the same edge.
        if (wb_p.ack) begin
          wb_d.stb   = 1'b0;
          tx_data_d  = wb_q.we ? RESP_OK : wb_p.dat;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end else if (cnt_q == CntLast) begin
          wb_d.stb   = 1'b0;
          terr_d     = 1'b1;
          tx_data_d  = RESP_TIMEOUT;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSend: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wb_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      terr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      terr_q     <= terr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_c        = wb_q;
  assign rx_ready    = rx_ready_int & ~rst;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_wb_byte_ctrl.sv
module tb_wb_byte_ctrl;
  import wb_byte_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  iWishbone_Ctrl wb_c;
  iWishbone_Peri wb_p;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [7:0]  exp_q[$];

  // Peripheral model: ack after (ack_wait+1) strobe cycles, or never.
  logic       ack_never = 1'b0;
  int         ack_wait = 0;
  int         stb_run = 0;
  int         stb_high = 0;
  logic [7:0] read_val = 8'h00;
  logic [7:0] dbg_reg = 8'h00;
  logic       ack_w;
  logic [7:0] pdat_w;

  assign ack_w  = wb_c.stb && !ack_never && (stb_run == ack_wait);
  assign pdat_w = (wb_c.adr == 8'd0) ? dbg_reg : read_val;
  assign wb_p   = {ack_w, pdat_w};

  always @(posedge clk) begin
    if (rst || !wb_c.stb || ack_w) stb_run <= 0;
    else                           stb_run <= stb_run + 1;
    if (wb_c.stb) stb_high <= stb_high + 1;
    if (wb_c.stb && ack_w && wb_c.we && wb_c.adr == 8'd0) dbg_reg <= wb_c.dat;
  end

  wb_byte_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_c        (wb_c),
    .wb_p        (wb_p),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Waits for tx_valid (tx_ready assumed 1), returns after the transfer edge.
  task automatic recv_tx(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'hxx;
    for (int i = 0; i < 100; i++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      b = tx_data;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({wb_c.stb, wb_c.we, wb_c.adr, wb_c.dat} !== 18'h0)
      $display("FAIL reset_wb: got %h want 0", {wb_c.stb, wb_c.we, wb_c.adr, wb_c.dat});
    else n_pass++;
    n_checks++;
    if ({tx_valid, tx_data, timeout_err} !== 10'h0)
      $display("FAIL reset_tx: got %h want 0", {tx_valid, tx_data, timeout_err});
    else n_pass++;
    n_checks++;
    if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b want 0", rx_ready);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b1) $display("FAIL idle_rx_ready: got %b want 1", rx_ready);
    else n_pass++;
  endtask

  task automatic test_read_zero_wait();
    bit ok;
    int s0;
    logic [7:0] e;
    ack_never = 1'b0;
    ack_wait  = 0;
    read_val  = 8'h5A;
    s0 = stb_high;
    exp_q.push_back(8'h5A);
    send_byte(8'h03, ok);
    n_checks++;
    if ({ok, wb_c.stb, wb_c.we, wb_c.adr, tx_valid} !== {1'b1, 1'b1, 1'b0, 8'd3, 1'b0})
      $display("FAIL rd_strobe: ok/stb/we/adr/txv got %b/%b/%b/%h/%b want 1/1/0/03/0",
               ok, wb_c.stb, wb_c.we, wb_c.adr, tx_valid);
    else n_pass++;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({tx_valid, tx_data, wb_c.stb} !== {1'b1, e, 1'b0})
      $display("FAIL rd_resp: txv/txd/stb got %b/%h/%b want 1/%h/0",
               tx_valid, tx_data, wb_c.stb, e);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stb_high - s0 !== 1) $display("FAIL rd_stb_cycles: got %0d want 1", stb_high - s0);
    else n_pass++;
    n_checks++;
    if ({tx_valid, timeout_err} !== 2'b00)
      $display("FAIL rd_after: txv/terr got %b/%b want 0/0", tx_valid, timeout_err);
    else n_pass++;
  endtask

  task automatic test_write();
    bit ok;
    int s0;
    logic [7:0] e, got;
    s0 = stb_high;
    exp_q.push_back(RESP_OK);
    send_byte(8'h80, ok);
    n_checks++;
    if ({ok, wb_c.stb, rx_ready} !== 3'b101)
      $display("FAIL wr_getdata: ok/stb/rx_ready got %b/%b/%b want 1/0/1", ok, wb_c.stb, rx_ready);
    else n_pass++;
    send_byte(8'hA5, ok);
    n_checks++;
    if ({ok, wb_c.stb, wb_c.we, wb_c.adr, wb_c.dat} !== {1'b1, 1'b1, 1'b1, 8'd0, 8'hA5})
      $display("FAIL wr_strobe: ok/stb/we/adr/dat got %b/%b/%b/%h/%h want 1/1/1/00/a5",
               ok, wb_c.stb, wb_c.we, wb_c.adr, wb_c.dat);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1) $display("FAIL wr_latency: tx_valid got %b want 1", tx_valid);
    else n_pass++;
    recv_tx(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if ({ok, got} !== {1'b1, e}) $display("FAIL wr_resp: got %b/%h want 1/%h", ok, got, e);
    else n_pass++;
    n_checks++;
    if (dbg_reg !== 8'hA5) $display("FAIL wr_dbg_reg: got %h want a5", dbg_reg);
    else n_pass++;
    n_checks++;
    if (stb_high - s0 !== 1) $display("FAIL wr_stb_cycles: got %0d want 1", stb_high - s0);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    bit ok;
    int s0;
    logic [7:0] e, got;
    ack_wait = 2;
    read_val = 8'h11;
    s0 = stb_high;
    exp_q.push_back(8'h11);
    send_byte(8'h05, ok);
    recv_tx(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if ({ok, got} !== {1'b1, e}) $display("FAIL ws_resp: got %b/%h want 1/%h", ok, got, e);
    else n_pass++;
    n_checks++;
    if (stb_high - s0 !== 3) $display("FAIL ws_stb_cycles: got %0d want 3", stb_high - s0);
    else n_pass++;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL ws_terr: got %b want 0", timeout_err);
    else n_pass++;
    n_checks++;
    if (wb_c.dat !== 8'hA5) $display("FAIL dat_hold: got %h want a5", wb_c.dat);
    else n_pass++;
    ack_wait = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    int s0;
    logic [7:0] e, got;
    ack_never = 1'b1;
    s0 = stb_high;
    exp_q.push_back(RESP_TIMEOUT);
    send_byte(8'h07, ok);
    recv_tx(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if ({ok, got} !== {1'b1, e}) $display("FAIL to_resp: got %b/%h want 1/%h", ok, got, e);
    else n_pass++;
    n_checks++;
    if (stb_high - s0 !== 16) $display("FAIL to_stb_cycles: got %0d want 16", stb_high - s0);
    else n_pass++;
    n_checks++;
    if ({timeout_err, wb_c.stb} !== 2'b10)
      $display("FAIL to_flag: terr/stb got %b/%b want 1/0", timeout_err, wb_c.stb);
    else n_pass++;
    ack_never = 1'b0;
    read_val  = 8'h42;
    exp_q.push_back(8'h42);
    send_byte(8'h04, ok);
    recv_tx(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if ({ok, got} !== {1'b1, e}) $display("FAIL to_next_resp: got %b/%h want 1/%h", ok, got, e);
    else n_pass++;
    n_checks++;
    if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_err);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    bit ok;
    logic [7:0] d0, e, got;
    tx_ready = 1'b0;
    read_val = 8'h3C;
    exp_q.push_back(8'h3C);
    send_byte(8'h01, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) $display("FAIL bp_wait: tx_valid got 0 want 1 within 50 cycles");
    else n_pass++;
    d0 = tx_data;
    read_val = 8'h77;
    exp_q.push_back(8'h77);
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_valid, tx_data, rx_ready, wb_c.stb} !== {1'b1, d0, 1'b0, 1'b0})
        $display("FAIL bp_stall[%0d]: txv/txd/rx_ready/stb got %b/%h/%b/%b want 1/%h/0/0",
                 i, tx_valid, tx_data, rx_ready, wb_c.stb, d0);
      else n_pass++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (d0 !== e) $display("FAIL bp_resp: got %h want %h", d0, e);
    else n_pass++;
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx_valid, rx_ready, wb_c.stb} !== 3'b010)
      $display("FAIL bp_release: txv/rx_ready/stb got %b/%b/%b want 0/1/0",
               tx_valid, rx_ready, wb_c.stb);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    n_checks++;
    if ({wb_c.stb, wb_c.adr} !== {1'b1, 8'd2})
      $display("FAIL bp_next_cmd: stb/adr got %b/%h want 1/02", wb_c.stb, wb_c.adr);
    else n_pass++;
    recv_tx(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if ({ok, got} !== {1'b1, e}) $display("FAIL bp_next_resp: got %b/%h want 1/%h", ok, got, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_cycle();
    bit ok;
    ack_never = 1'b1;
    send_byte(8'h06, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ok, wb_c.stb} !== 2'b11) $display("FAIL rm_pending: ok/stb got %b/%b want 1/1", ok, wb_c.stb);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({wb_c.stb, tx_valid, rx_ready, timeout_err} !== 4'b0000)
      $display("FAIL rm_abort: stb/txv/rx_ready/terr got %b/%b/%b/%b want 0/0/0/0",
               wb_c.stb, tx_valid, rx_ready, timeout_err);
    else n_pass++;
    rst = 1'b0;
    ack_never = 1'b0;
    #1;
    n_checks++;
    if (rx_ready !== 1'b1) $display("FAIL rm_rx_ready: got %b want 1", rx_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_valid, wb_c.stb} !== 2'b00)
        $display("FAIL rm_quiet[%0d]: txv/stb got %b/%b want 0/0", i, tx_valid, wb_c.stb);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_empty: got %0d entries want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read_zero_wait();
    test_write();
    test_wait_states();
    test_timeout();
    test_back_pressure();
    test_reset_mid_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
